// File: rtl/mem_access_arbiter.sv
// Shares the single data memory between instruction fetch (read-only) and load/store.
// Round-robin grant, latched request, stretched access, one-cycle ack with registered read data.
module mem_access_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 1,
  parameter int unsigned ADDR_WORDS    = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [17:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic        ls_byte,
  input  logic [17:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_ack,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic [17:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_byte,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(ACCESS_CYCLES - 1);
  localparam logic          SINGLE_CYCLE = (ACCESS_CYCLES == 32'd1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          owner_ls;
  logic          rr_last_ls;
  logic          cur_we;

  logic          pick_ls;
  logic [AW-1:0] grant_addr;
  logic          grant_we;
  logic          grant_oor;

  // When both request, the side not served last wins.
  always_comb begin
    pick_ls    = ls_req && (!if_req || !rr_last_ls);
    grant_addr = pick_ls ? ls_addr : if_addr;
    grant_we   = pick_ls && ls_we;
    grant_oor  = 32'(grant_addr) >= ADDR_WORDS;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      owner_ls       <= 1'b0;
      rr_last_ls     <= 1'b1;
      cur_we         <= 1'b0;
      if_ack         <= 1'b0;
      if_rdata       <= '0;
      if_err         <= 1'b0;
      ls_ack         <= 1'b0;
      ls_rdata       <= '0;
      ls_err         <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_byte       <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      ls_ack <= 1'b0;
      if_err <= 1'b0;
      ls_err <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || ls_req) begin
            owner_ls   <= pick_ls;
            rr_last_ls <= pick_ls;
            cur_we     <= grant_we;
            if (grant_oor) begin
              // Out-of-range: answer immediately, memory untouched.
              state <= RESP;
              if (pick_ls) begin
                ls_ack   <= 1'b1;
                ls_err   <= 1'b1;
                ls_rdata <= '0;
              end else begin
                if_ack   <= 1'b1;
                if_err   <= 1'b1;
                if_rdata <= '0;
              end
            end else begin
              state       <= ACCESS;
              cnt         <= CNT_INIT;
              mem_address <= grant_addr;
              mem_byte    <= pick_ls && ls_byte;
              if (pick_ls) mem_write_data <= ls_wdata;
              mem_read    <= !grant_we;
              mem_write   <= grant_we && SINGLE_CYCLE;
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state     <= RESP;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (owner_ls) begin
              ls_ack   <= 1'b1;
              ls_rdata <= DW'(mem_read_data);
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= DW'(mem_read_data);
            end
          end else begin
            cnt       <= cnt - CW'(1);
            // Write strobe only in the final access cycle.
            mem_write <= cur_we && (cnt == CW'(1));
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Randomized bench for mem_access_arbiter with a transaction-level reference model
// and a behavioural memory that follows the arbiter's strobes.
module tb_mem_access_arbiter;

  localparam int AC    = 3;
  localparam int WORDS = 256;
  localparam int BOUND = 3 * (AC + 2);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tb_init = 1'b1;
  logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0, ls_byte = 1'b0;
  logic [17:0] if_addr = '0, ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        if_ack, if_err, ls_ack, ls_err;
  logic [31:0] if_rdata, ls_rdata;
  logic [17:0] mem_address;
  logic [31:0] mem_write_data, mem_read_data;
  logic        mem_read, mem_write, mem_byte;

  mem_access_arbiter #(.ACCESS_CYCLES(AC), .ADDR_WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_byte(ls_byte), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte(mem_byte), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] seed_word(input int a);
    return (a == 5) ? 32'hDEADBEEF : (32'(a) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Memory block: combinational read (byte reads zero-extended), write on clock edge.
  logic [31:0] mem [0:WORDS-1];
  assign mem_read_data = mem_byte ? {24'h0, mem[mem_address[7:0]][7:0]} : mem[mem_address[7:0]];
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= seed_word(i);
    end else if (mem_write) begin
      if (mem_byte) mem[mem_address[7:0]][7:0] <= mem_write_data[7:0];
      else          mem[mem_address[7:0]]      <= mem_write_data;
    end
  end

  int checks = 0, errors = 0, ecount = 0, mw_cycles = 0, if_wait = 0, ls_wait = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, ecount);
    end
  endtask

  // Reference model: one transaction at a time, timed from its grant edge.
  logic [31:0] ref_mem [0:WORDS-1];
  int          next_grant = 0, t_g = 0, t_ack = 0;
  bit          has_txn = 0, last_ls = 1, t_ls, t_we, t_byte, t_oor;
  logic [17:0] t_addr;
  logic [31:0] t_wdata, t_rdata;
  bit          if_known = 1, ls_known = 1;
  logic [31:0] exp_if_rd = '0, exp_ls_rd = '0;

  task automatic model_reset();
    has_txn = 0; next_grant = 0; last_ls = 1;
    if_known = 1; ls_known = 1; exp_if_rd = '0; exp_ls_rd = '0;
    if_wait = 0; ls_wait = 0;
  endtask

  task automatic model_step();
    bit e_ifa, e_lsa, e_rd, e_wr;
    if (ecount >= next_grant && (if_req || ls_req)) begin
      t_ls    = ls_req && (!if_req || !last_ls);
      last_ls = t_ls;
      t_addr  = t_ls ? ls_addr : if_addr;
      t_we    = t_ls && ls_we;
      t_byte  = t_ls && ls_byte;
      t_wdata = ls_wdata;
      t_oor   = int'(t_addr) >= WORDS;
      t_g     = ecount;
      t_ack   = ecount + (t_oor ? 0 : AC);
      next_grant = t_ack + 2;
      has_txn = 1;
      if (t_oor)       t_rdata = '0;
      else if (t_byte) t_rdata = {24'h0, ref_mem[t_addr[7:0]][7:0]};
      else             t_rdata = ref_mem[t_addr[7:0]];
    end
    e_rd  = has_txn && !t_oor && !t_we && ecount >= t_g && ecount < t_g + AC;
    e_wr  = has_txn && !t_oor && t_we && ecount == t_g + AC - 1;
    e_ifa = has_txn && !t_ls && ecount == t_ack;
    e_lsa = has_txn && t_ls && ecount == t_ack;
    check("if_ack", 32'(if_ack), 32'(e_ifa));
    check("ls_ack", 32'(ls_ack), 32'(e_lsa));
    check("mem_read", 32'(mem_read), 32'(e_rd));
    check("mem_write", 32'(mem_write), 32'(e_wr));
    if (e_rd || e_wr) begin
      check("mem_address", 32'(mem_address), 32'(t_addr));
      check("mem_byte", 32'(mem_byte), 32'(t_byte));
    end
    if (e_wr) check("mem_write_data", mem_write_data, t_wdata);
    if (e_ifa) begin
      check("if_err", 32'(if_err), 32'(t_oor));
      exp_if_rd = t_rdata;
    end
    if (e_lsa) begin
      check("ls_err", 32'(ls_err), 32'(t_oor));
      if (t_we && !t_oor) begin
        ls_known = 0;
        if (t_byte) ref_mem[t_addr[7:0]][7:0] = t_wdata[7:0];
        else        ref_mem[t_addr[7:0]]      = t_wdata;
      end else begin
        ls_known  = 1;
        exp_ls_rd = t_rdata;
      end
    end
    if (if_known) check("if_rdata", if_rdata, exp_if_rd);
    if (ls_known) check("ls_rdata", ls_rdata, exp_ls_rd);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ecount++;
    if (mem_write) mw_cycles++;
    model_step();
    if (if_req && !if_ack) if_wait++; else if_wait = 0;
    if (ls_req && !ls_ack) ls_wait++; else ls_wait = 0;
    if (if_wait > BOUND) begin check("if_starved", 32'(if_wait), 32'(BOUND)); if_wait = 0; end
    if (ls_wait > BOUND) begin check("ls_starved", 32'(ls_wait), 32'(BOUND)); ls_wait = 0; end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_if_ack"}, 32'(if_ack), 32'd0);
    check({tag, "_if_rdata"}, if_rdata, 32'd0);
    check({tag, "_if_err"}, 32'(if_err), 32'd0);
    check({tag, "_ls_ack"}, 32'(ls_ack), 32'd0);
    check({tag, "_ls_rdata"}, ls_rdata, 32'd0);
    check({tag, "_ls_err"}, 32'(ls_err), 32'd0);
    check({tag, "_mem_address"}, 32'(mem_address), 32'd0);
    check({tag, "_mem_write_data"}, mem_write_data, 32'd0);
    check({tag, "_mem_read"}, 32'(mem_read), 32'd0);
    check({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    check({tag, "_mem_byte"}, 32'(mem_byte), 32'd0);
  endtask

  task automatic txn(input bit on_ls, input logic we, input logic is_byte, input logic [17:0] addr,
                     input logic [31:0] wd, output logic [31:0] rd, output logic err, output int lat);
    bit got;
    lat = 0;
    if (on_ls) begin
      ls_req = 1; ls_we = we; ls_byte = is_byte; ls_addr = addr; ls_wdata = wd;
    end else begin
      if_req = 1; if_addr = addr;
    end
    do begin
      step();
      lat++;
      got = on_ls ? ls_ack : if_ack;
    end while (!got && lat < 40);
    check("txn_done", 32'(got), 32'd1);
    rd  = on_ls ? ls_rdata : if_rdata;
    err = on_ls ? ls_err : if_err;
    if (on_ls) ls_req = 0; else if_req = 0;
    step();
  endtask

  function automatic logic [17:0] rand_addr();
    int unsigned r = $urandom_range(0, 11);
    if (r == 0) return 18'h3FFFF;
    if (r == 1) return 18'(WORDS);
    if (r == 2) return 18'(WORDS - 1);
    if (r == 3) return 18'($urandom_range(WORDS, 32'h3FFFE));
    return 18'($urandom_range(0, 15));
  endfunction

  initial begin
    logic [31:0] rd, saved;
    logic        err;
    int          lat, mw0, nacks, guard;
    bit          order [0:3];

    for (int i = 0; i < WORDS; i++) ref_mem[i] = seed_word(i);
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0; tb_init = 0;
    repeat (2) step();

    // IF read of a known word
    txn(0, 0, 0, 18'd5, '0, rd, err, lat);
    check("if_read_data", rd, 32'hDEADBEEF);
    check("if_read_err", 32'(err), 32'd0);
    check("if_latency", 32'(lat), 32'(AC + 1));

    // Word write then read back; exactly one write strobe cycle
    mw0 = mw_cycles;
    txn(1, 1, 0, 18'd7, 32'h12345678, rd, err, lat);
    check("wr_pulse", 32'(mw_cycles - mw0), 32'd1);
    txn(1, 0, 0, 18'd7, '0, rd, err, lat);
    check("word_read", rd, 32'h12345678);

    // Byte write merges low byte only
    txn(1, 1, 1, 18'd7, 32'h000000AA, rd, err, lat);
    txn(1, 0, 1, 18'd7, '0, rd, err, lat);
    check("byte_read", rd, 32'h000000AA);
    txn(1, 0, 0, 18'd7, '0, rd, err, lat);
    check("word_after_byte", rd, 32'h123456AA);

    // Out-of-range accesses
    mw0 = mw_cycles;
    txn(1, 1, 0, 18'd300, 32'hFFFF0000, rd, err, lat);
    check("oor_err", 32'(err), 32'd1);
    check("oor_latency", 32'(lat), 32'd1);
    check("oor_no_write", 32'(mw_cycles - mw0), 32'd0);
    txn(0, 0, 0, 18'h3FFFF, '0, rd, err, lat);
    check("oor_max_err", 32'(err), 32'd1);
    check("oor_max_rdata", rd, 32'd0);
    txn(0, 0, 0, 18'd256, '0, rd, err, lat);
    check("oor_edge_err", 32'(err), 32'd1);
    txn(0, 0, 0, 18'd255, '0, rd, err, lat);
    check("last_word_err", 32'(err), 32'd0);
    check("last_word_data", rd, seed_word(255));

    // Reset in the second access cycle of a write abandons it
    saved = mem[9];
    ls_req = 1; ls_we = 1; ls_byte = 0; ls_addr = 18'd9; ls_wdata = ~saved;
    step();
    step();
    #2 rst = 1;
    #1 check_all_zero("midreset");
    ls_req = 0;
    repeat (2) @(posedge clk);
    #1 check("midreset_mem", mem[9], saved);
    @(negedge clk);
    rst = 0;
    model_reset();

    // Both request after reset: IF first, then alternate
    if_req = 1; if_addr = 18'd3;
    ls_req = 1; ls_we = 0; ls_byte = 0; ls_addr = 18'd4;
    nacks = 0; guard = 0;
    while (nacks < 4 && guard < 60) begin
      step();
      guard++;
      if (if_ack || ls_ack) begin
        order[nacks] = ls_ack;
        nacks++;
        if (nacks >= 3) begin
          if (if_ack) if_req = 0;
          if (ls_ack) ls_req = 0;
        end
      end
    end
    check("rr_count", 32'(nacks), 32'd4);
    for (int i = 0; i < 4; i++) check("rr_order", 32'(order[i]), 32'(i % 2));
    repeat (2) step();

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      step();
      if (if_ack) if_req = 0;
      if (ls_ack) ls_req = 0;
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = rand_addr();
      end
      if (!ls_req && $urandom_range(0, 2) == 0) begin
        ls_req = 1; ls_addr = rand_addr(); ls_we = 1'($urandom_range(0, 1));
        ls_byte = ($urandom_range(0, 3) == 0); ls_wdata = $urandom;
      end
    end

    guard = 0;
    while ((if_req || ls_req) && guard < 100) begin
      step();
      guard++;
      if (if_ack) if_req = 0;
      if (ls_ack) ls_req = 0;
    end
    check("drain", {30'd0, if_req, ls_req}, 32'd0);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
